// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution stage.
// The funct3 encoder uses the same ENC_* constants.
package branch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic ENC_BGE = 1'b0;
   localparam logic ENC_BNE = 1'b1;

   localparam int FLUSH_CNT_W = 4;

   typedef struct packed {
      logic is_branch;
      logic encoded_branch;
      logic alu_zero;
      logic alu_lt;
   } br_flags_t;

   // BNE is taken when the operands differ; BGE is taken when rs1 is not below rs2
   function automatic logic branch_taken(input br_flags_t f);
      return f.is_branch & ((f.encoded_branch == ENC_BNE) ? ~f.alu_zero : ~f.alu_lt);
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Request/result bundle between the branch resolver and its neighbouring stages.
interface branch_resolver_if #(
   parameter int XLEN   = 32,
   parameter int STAT_W = 32
);
   logic              br_valid;
   logic              br_ready;
   logic              is_branch;
   logic              encoded_branch;
   logic              alu_zero;
   logic              alu_lt;
   logic [XLEN-1:0]   target_addr;
   logic [XLEN-1:0]   pc_plus4;
   logic              out_valid;
   logic              out_ready;
   logic              pc_source;
   logic [XLEN-1:0]   next_pc;
   logic              misaligned;
   logic              flush;
   logic [STAT_W-1:0] taken_count;
   logic [STAT_W-1:0] resolved_count;

   modport slave (
      input  br_valid, is_branch, encoded_branch, alu_zero, alu_lt,
             target_addr, pc_plus4, out_ready,
      output br_ready, out_valid, pc_source, next_pc, misaligned, flush,
             taken_count, resolved_count
   );

   modport master (
      output br_valid, is_branch, encoded_branch, alu_zero, alu_lt,
             target_addr, pc_plus4, out_ready,
      input  br_ready, out_valid, pc_source, next_pc, misaligned, flush,
             taken_count, resolved_count
   );
endinterface

// File: rtl/branch_stats.sv
// Saturating taken/resolved counter pair for the branch resolver.
module branch_stats #(
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_taken,
   input  logic              inc_resolved,
   output logic [STAT_W-1:0] taken_count,
   output logic [STAT_W-1:0] resolved_count
);

   logic [STAT_W-1:0] taken_q, taken_d;
   logic [STAT_W-1:0] resolved_q, resolved_d;

   // Counters stick at all-ones rather than wrapping
   always_comb begin
      taken_d    = taken_q;
      resolved_d = resolved_q;
      if (inc_taken && !(&taken_q)) taken_d = taken_q + 1'b1;
      if (inc_resolved && !(&resolved_q)) resolved_d = resolved_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q    <= '0;
         resolved_q <= '0;
      end else begin
         taken_q    <= taken_d;
         resolved_q <= resolved_d;
      end
   end

   assign taken_count    = taken_q;
   assign resolved_count = resolved_q;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution stage: decides taken/not-taken, drives next PC and a timed flush.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int STAT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   branch_resolver_if.slave bus
);

   localparam bit FLUSH_EN = (FLUSH_CYCLES > 0);
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

   state_t                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   br_flags_t              flags_q, flags_d;
   logic [XLEN-1:0]        target_q, target_d;
   logic [XLEN-1:0]        pc4_q, pc4_d;

   logic raw_taken;
   logic mis_raw;
   logic take;

   // All result outputs come from the captured operands, never the live inputs
   assign raw_taken = branch_taken(flags_q);
   assign mis_raw   = raw_taken & (target_q[1:0] != 2'b00);
   assign take      = raw_taken & ~mis_raw;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flags_d  = flags_q;
      target_d = target_q;
      pc4_d    = pc4_q;
      case (state_q)
         IDLE: begin
            if (bus.br_valid) begin
               flags_d  = '{is_branch:      bus.is_branch,
                            encoded_branch: bus.encoded_branch,
                            alu_zero:       bus.alu_zero,
                            alu_lt:         bus.alu_lt};
               target_d = bus.target_addr;
               pc4_d    = bus.pc_plus4;
               state_d  = EVAL;
            end
         end
         EVAL: begin
            if (bus.out_ready) begin
               if (take && FLUSH_EN) begin
                  state_d = FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         FLUSH: begin
            // Leave on the cycle the count would hit zero so flush lasts FLUSH_CYCLES cycles
            if (cnt_q <= 1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         flags_q  <= '0;
         target_q <= '0;
         pc4_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flags_q  <= flags_d;
         target_q <= target_d;
         pc4_q    <= pc4_d;
      end
   end

   assign bus.br_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == EVAL);
   assign bus.pc_source  = (state_q == EVAL) & take;
   assign bus.misaligned = (state_q == EVAL) & mis_raw;
   assign bus.next_pc    = take ? target_q : pc4_q;
   assign bus.flush      = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
   logic result_accept;
   assign result_accept = (state_q == EVAL) & bus.out_ready;

   branch_stats #(.STAT_W(STAT_W)) u_stats (
      .clk            (clk),
      .rst_n          (rst_n),
      .inc_taken      (result_accept & take),
      .inc_resolved   (result_accept),
      .taken_count    (bus.taken_count),
      .resolved_count (bus.resolved_count)
   );
`else
   assign bus.taken_count    = '0;
   assign bus.resolved_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver; expectations come from rs1/rs2 values
// and branch semantics. Counter expectations follow BRANCH_STATS_EN.
module tb_branch_resolver;

   localparam int XLEN = 32;
   localparam int STAT_W = 32;
   localparam int FLUSH_CYCLES = 2;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   exp_taken_cnt;
   int   exp_resolved_cnt;

   branch_resolver_if #(.XLEN(XLEN), .STAT_W(STAT_W)) bus ();

   branch_resolver #(
      .XLEN         (XLEN),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .STAT_W       (STAT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [STAT_W-1:0] want_count(input int c);
`ifdef BRANCH_STATS_EN
      return STAT_W'(c);
`else
      return '0;
`endif
   endfunction

   // One full branch transaction with optional stall cycles in EVAL
   task automatic run_branch(input logic is_br, input logic enc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] target, input logic [31:0] pc4,
                             input int stall);
      logic        e_raw, e_mis, e_src;
      logic [31:0] e_pc;
      logic [31:0] junk;
      e_raw = is_br && (enc ? (rs1 != rs2) : ($signed(rs1) >= $signed(rs2)));
      e_mis = e_raw && ((target % 4) != 0);
      e_src = e_raw && !e_mis;
      e_pc  = e_src ? target : pc4;

      bus.br_valid       = 1'b1;
      bus.is_branch      = is_br;
      bus.encoded_branch = enc;
      bus.alu_zero       = (rs1 == rs2);
      bus.alu_lt         = ($signed(rs1) < $signed(rs2));
      bus.target_addr    = target;
      bus.pc_plus4       = pc4;
      bus.out_ready      = 1'b0;
      n_cmp++;
      if (bus.br_ready !== 1'b1) begin
         n_err++; $display("[TB] FAIL req_ready: got %b want 1", bus.br_ready);
      end
      step();
      bus.br_valid = 1'b0;

      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.br_ready !== 1'b0 || bus.flush !== 1'b0) begin
         n_err++; $display("[TB] FAIL eval_state: valid/ready/flush got %b%b%b want 100",
                           bus.out_valid, bus.br_ready, bus.flush);
      end
      n_cmp++;
      if (bus.pc_source !== e_src || bus.misaligned !== e_mis || bus.next_pc !== e_pc) begin
         n_err++; $display("[TB] FAIL result: src/mis/pc got %b %b %h want %b %b %h",
                           bus.pc_source, bus.misaligned, bus.next_pc, e_src, e_mis, e_pc);
      end

      for (int i = 0; i < stall; i++) begin
         junk               = $urandom;
         bus.br_valid       = 1'b1;
         bus.is_branch      = ~is_br;
         bus.encoded_branch = ~enc;
         bus.alu_zero       = junk[0];
         bus.alu_lt         = junk[1];
         bus.target_addr    = junk ^ target;
         bus.pc_plus4       = ~pc4;
         step();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.pc_source !== e_src ||
             bus.misaligned !== e_mis || bus.next_pc !== e_pc) begin
            n_err++; $display("[TB] FAIL stall_hold[%0d]: valid/src/pc got %b %b %h want 1 %b %h",
                              i, bus.out_valid, bus.pc_source, bus.next_pc, e_src, e_pc);
         end
      end

      bus.br_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      exp_resolved_cnt++;
      if (e_src) exp_taken_cnt++;

      if (e_src && FLUSH_CYCLES > 0) begin
         for (int k = 0; k < FLUSH_CYCLES; k++) begin
            n_cmp++;
            if (bus.flush !== 1'b1 || bus.br_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
               n_err++; $display("[TB] FAIL flush_cycle[%0d]: flush/ready/valid got %b%b%b want 100",
                                 k, bus.flush, bus.br_ready, bus.out_valid);
            end
            step();
         end
      end
      n_cmp++;
      if (bus.flush !== 1'b0 || bus.br_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++; $display("[TB] FAIL back_to_idle: flush/ready/valid got %b%b%b want 010",
                           bus.flush, bus.br_ready, bus.out_valid);
      end
      n_cmp++;
      if (bus.taken_count !== want_count(exp_taken_cnt) ||
          bus.resolved_count !== want_count(exp_resolved_cnt)) begin
         n_err++; $display("[TB] FAIL counters: taken/resolved got %0d/%0d want %0d/%0d",
                           bus.taken_count, bus.resolved_count,
                           want_count(exp_taken_cnt), want_count(exp_resolved_cnt));
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if (bus.br_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.pc_source !== 1'b0 ||
          bus.misaligned !== 1'b0 || bus.flush !== 1'b0) begin
         n_err++; $display("[TB] FAIL reset_ctrl: ready/valid/src/mis/flush got %b%b%b%b%b want 10000",
                           bus.br_ready, bus.out_valid, bus.pc_source, bus.misaligned, bus.flush);
      end
      n_cmp++;
      if (bus.next_pc !== 32'h0 || bus.taken_count !== '0 || bus.resolved_count !== '0) begin
         n_err++; $display("[TB] FAIL reset_data: pc/taken/resolved got %h/%0d/%0d want 0/0/0",
                           bus.next_pc, bus.taken_count, bus.resolved_count);
      end
   endtask

   task automatic test_taken_flush();
      run_branch(1'b1, 1'b1, 32'd5, 32'd7, 32'h0000_0100, 32'h0000_0084, 0);
   endtask

   task automatic test_not_taken();
      run_branch(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd4, 32'h0000_0200, 32'h0000_0048, 0);
      run_branch(1'b0, 1'b1, 32'd1, 32'd2, 32'h0000_0300, 32'h0000_0050, 0);
   endtask

   task automatic test_misaligned();
      run_branch(1'b1, 1'b1, 32'd9, 32'd3, 32'h0000_0102, 32'h0000_0084, 0);
   endtask

   task automatic test_stall();
      run_branch(1'b1, 1'b0, 32'd10, 32'd10, 32'h0000_0400, 32'h0000_0010, 5);
   endtask

   task automatic test_reset_in_flush();
      run_branch(1'b1, 1'b1, 32'd1, 32'd0, 32'h0000_0800, 32'h0000_0020, 0);
      bus.br_valid       = 1'b1;
      bus.is_branch      = 1'b1;
      bus.encoded_branch = 1'b1;
      bus.alu_zero       = 1'b0;
      bus.alu_lt         = 1'b0;
      bus.target_addr    = 32'h0000_0900;
      bus.pc_plus4       = 32'h0000_0024;
      step();
      bus.br_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.flush !== 1'b1) begin
         n_err++; $display("[TB] FAIL flush_before_reset: got %b want 1", bus.flush);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.flush !== 1'b0 || bus.br_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++; $display("[TB] FAIL async_reset: flush/ready/valid got %b%b%b want 010",
                           bus.flush, bus.br_ready, bus.out_valid);
      end
      step();
      rst_n = 1'b1;
      exp_taken_cnt    = 0;
      exp_resolved_cnt = 0;
      step();
      n_cmp++;
      if (bus.br_ready !== 1'b1 || bus.flush !== 1'b0 || bus.taken_count !== '0 ||
          bus.resolved_count !== '0) begin
         n_err++; $display("[TB] FAIL after_reset: ready/flush/taken/resolved got %b%b %0d/%0d want 10 0/0",
                           bus.br_ready, bus.flush, bus.taken_count, bus.resolved_count);
      end
   endtask

   task automatic test_stats();
      run_branch(1'b1, 1'b1, 32'd3, 32'd4, 32'h0000_1000, 32'h0000_0100, 0);
      run_branch(1'b1, 1'b0, 32'd2, 32'd9, 32'h0000_1004, 32'h0000_0104, 0);
      run_branch(1'b1, 1'b0, 32'd9, 32'd2, 32'h0000_1008, 32'h0000_0108, 1);
      run_branch(1'b1, 1'b1, 32'd6, 32'd6, 32'h0000_100C, 32'h0000_010C, 0);
      run_branch(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_1010, 32'h0000_0110, 0);
      n_cmp++;
      if (bus.taken_count !== want_count(3) || bus.resolved_count !== want_count(5)) begin
         n_err++; $display("[TB] FAIL stats_total: taken/resolved got %0d/%0d want %0d/%0d",
                           bus.taken_count, bus.resolved_count, want_count(3), want_count(5));
      end
   endtask

   task automatic test_random();
      logic [31:0] r1, r2, tgt, pc4, lowb;
      logic        isb, enc;
      for (int i = 0; i < 24; i++) begin
         r1   = $urandom;
         r2   = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
         isb  = ($urandom_range(0, 4) != 0);
         enc  = 1'($urandom_range(0, 1));
         tgt  = $urandom & 32'hFFFF_FFFC;
         lowb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
         tgt  = tgt | lowb;
         pc4  = $urandom & 32'hFFFF_FFFC;
         run_branch(isb, enc, r1, r2, tgt, pc4, $urandom_range(0, 2));
      end
   endtask

   initial begin
      n_cmp            = 0;
      n_err            = 0;
      exp_taken_cnt    = 0;
      exp_resolved_cnt = 0;
      rst_n              = 1'b0;
      bus.br_valid       = 1'b0;
      bus.is_branch      = 1'b0;
      bus.encoded_branch = 1'b0;
      bus.alu_zero       = 1'b0;
      bus.alu_lt         = 1'b0;
      bus.target_addr    = '0;
      bus.pc_plus4       = '0;
      bus.out_ready      = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      test_reset();
      test_taken_flush();
      test_not_taken();
      test_misaligned();
      test_stall();
      test_random();
      test_reset_in_flush();
      test_stats();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution stage of the RISCV32 core. It consumes the 1-bit encoded branch type produced from funct3 (BGE=0, BNE=1) together with the ALU comparison flags, and decides taken/not-taken. It then drives pcsource and the next PC to the PC-update stage through a valid/ready handshake, and issues a timed pipeline flush on taken branches.

## Interface
Parameters:
- XLEN, 32: address width.
- FLUSH_CYCLES, 2: cycles flush is held after a taken branch; legal range 0..15.
- STAT_W, 32: width of statistics counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- br_valid  in  1  branch request valid.
- br_ready  out  1  resolver can accept a request.
- is_branch  in  1  control unit flags a conditional branch; 0 means not taken.
- encoded_branch  in  1  0 = BGE, 1 = BNE.
- alu_zero  in  1  rs1 == rs2.
- alu_lt  in  1  rs1 < rs2, signed.
- target_addr  in  XLEN  branch target (PC + imm).
- pc_plus4  in  XLEN  fall-through address.
- out_valid  out  1  resolution result valid.
- out_ready  in  1  PC stage accepts the result.
- pc_source  out  1  1 = take target_addr.
- next_pc  out  XLEN  selected next PC.
- misaligned  out  1  taken target with bits [1:0] != 0.
- flush  out  1  squash younger instructions.
- taken_count  out  STAT_W  taken branches resolved.
- resolved_count  out  STAT_W  all results accepted.

## Operation
- FSM states: IDLE, EVAL, FLUSH.
- IDLE:
  - br_ready = 1.
  - On br_valid & br_ready: register is_branch, encoded_branch, alu_zero, alu_lt, target_addr and pc_plus4, then go to EVAL.
- EVAL:
  - out_valid = 1; all outputs are computed from registered operands only.
  - raw_taken = is_branch & (encoded_branch ? ~alu_zero : ~alu_lt).
  - misaligned = raw_taken & (target_addr[1:0] != 0).
  - pc_source = raw_taken & ~misaligned.
  - next_pc = pc_source ? target_addr : pc_plus4.
  - Outputs hold stable while out_ready = 0.
  - On out_valid & out_ready: if pc_source and FLUSH_CYCLES > 0, go to FLUSH and load the counter with FLUSH_CYCLES. Otherwise go to IDLE.
- FLUSH:
  - flush = 1; the counter decrements each cycle.
  - Go to IDLE when the counter would reach 0, so flush is high for exactly FLUSH_CYCLES cycles.
  - br_ready = 0.
- Misaligned results never flush; the trap is handled downstream.
- br_valid outside IDLE is ignored. The requester must hold its request until br_ready.
- Reset mid-operation returns to IDLE and discards the captured branch and any pending flush.

## Timing
- Reset values:
  - state = IDLE, so br_ready = 1.
  - out_valid, pc_source, misaligned and flush = 0.
  - next_pc = 0; both counters = 0.
- Request handshake in cycle N puts out_valid high in cycle N+1. Resolution latency is 1 cycle.
- Result handshake in cycle M:
  - Not-taken, or FLUSH_CYCLES = 0: br_ready = 1 in M+1, so one request every 2 cycles at best.
  - Taken: flush is high in cycles M+1 .. M+FLUSH_CYCLES, and br_ready returns in cycle M+FLUSH_CYCLES+1.
- br_ready and out_valid are decoded from registered state only. There is no combinational path from br_valid or out_ready.

## Configuration
- BRANCH_STATS_EN defined:
  - taken_count increments on each accepted result with pc_source = 1.
  - resolved_count increments on each accepted result.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: the counter logic is removed. taken_count and resolved_count are tied to 0 and the ports remain.

## Structure
- Shared package branch_pkg holds:
  - state enum {IDLE, EVAL, FLUSH};
  - ENC_BGE = 1'b0 and ENC_BNE = 1'b1 constants, shared with the funct3 encoder;
  - the flush counter width constant (4 bits).
- One sub-module, branch_stats: the saturating counter pair, instantiated only under BRANCH_STATS_EN.

## Test plan
- BNE, zero=0, target 0x0000_0100, pc_plus4 0x0000_0084, out_ready=1:
  - pc_source=1 and next_pc=0x100 one cycle after the request;
  - flush high for 2 cycles; br_ready returns 3 cycles after the result handshake.
- BGE, alu_lt=1: pc_source=0, next_pc=pc_plus4, no flush, br_ready=1 on the cycle after acceptance.
- BNE taken with target 0x0000_0102: misaligned=1, pc_source=0, next_pc=pc_plus4, flush never asserted.
- out_ready held 0 for 5 cycles in EVAL: out_valid, next_pc and pc_source stay constant, and new br_valid pulses are ignored.
- rst_n low during FLUSH: flush drops immediately and asynchronously, with state IDLE and br_ready=1 after release.
- BRANCH_STATS_EN, 3 taken and 2 not-taken results: taken_count=3 and resolved_count=5. Without the macro both read 0.
